// File: rtl/clk_div_prog.sv
// ============================================================================
// Module   : clk_div_prog
// Brief    : Programmable clock-enable generator (pulse or square output) with
//            a shadowed divisor that is applied at period boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_prog #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                 clk_100Mhz,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] div_value,
    input  logic                 div_load,
    output logic                 tick_out,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 load_pending
);

    localparam logic [CNT_WIDTH-1:0] c_default_div = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] c_one         = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic                 r_pending;
    logic                 r_tick;
    logic                 r_mode;

    logic                 w_mode_change;
    logic                 w_terminal;
    logic [CNT_WIDTH-1:0] w_clamped;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_div_nxt;
    logic [CNT_WIDTH-1:0] w_shadow_nxt;
    logic                 w_pending_nxt;
    logic                 w_tick_nxt;

    // r_div is never zero, so r_div - 1 cannot underflow.
    always_comb begin
        w_mode_change = (mode != r_mode);
        w_terminal    = enable && !w_mode_change && (r_count == r_div - c_one);
        w_clamped     = (div_value == '0) ? c_one : div_value;
    end

    always_comb begin
        w_count_nxt   = r_count;
        w_div_nxt     = r_div;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_tick_nxt    = r_tick;

        if (w_mode_change) begin
            w_count_nxt = '0;
            w_tick_nxt  = 1'b0;
        end else if (enable) begin
            w_count_nxt = w_terminal ? '0 : r_count + c_one;
            w_tick_nxt  = mode ? (r_tick ^ w_terminal) : w_terminal;
        end else begin
            w_tick_nxt  = mode ? r_tick : 1'b0;
        end

        // An idle counter or a boundary edge lets a new divisor take effect at once.
        if (div_load) begin
            w_shadow_nxt = w_clamped;
            if (!enable || w_terminal) begin
                w_div_nxt     = w_clamped;
                w_pending_nxt = 1'b0;
                if (!enable) begin
                    w_count_nxt = '0;
                end
            end else begin
                w_pending_nxt = 1'b1;
            end
        end else if (w_terminal && r_pending) begin
            w_div_nxt     = r_shadow;
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            r_count   <= '0;
            r_div     <= c_default_div;
            r_shadow  <= c_default_div;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_mode    <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_div     <= w_div_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_tick    <= w_tick_nxt;
            r_mode    <= mode;
        end
    end

    assign tick_out     = r_tick;
    assign div_active   = r_div;
    assign load_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module   : tb_clk_div_prog
// Brief    : Directed and randomized checks of clk_div_prog against a
//            period-position reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_prog;

    localparam int W = 16;

    logic         clk_100Mhz = 1'b0;
    logic         reset      = 1'b1;
    logic         enable     = 1'b0;
    logic         mode       = 1'b0;
    logic [W-1:0] div_value  = '0;
    logic         div_load   = 1'b0;
    logic         tick_out;
    logic [W-1:0] div_active;
    logic         load_pending;

    int errors = 0;
    int checks = 0;

    // Reference state: position inside the current period and the divisor in use.
    int m_pos;
    int m_div;
    int m_shadow;
    bit m_pending;
    bit m_tick;
    bit m_square;

    clk_div_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(10)) dut (
        .clk_100Mhz  (clk_100Mhz),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .div_value   (div_value),
        .div_load    (div_load),
        .tick_out    (tick_out),
        .div_active  (div_active),
        .load_pending(load_pending)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit md, input int dv, input bit ld);
        int nv;
        bit boundary;
        if (r) begin
            m_pos = 0; m_div = 10; m_shadow = 10;
            m_pending = 0; m_tick = 0; m_square = 0;
            return;
        end
        nv = (dv == 0) ? 1 : dv;
        boundary = 0;
        if (md != m_square) begin
            m_square = md;
            m_pos    = 0;
            m_tick   = 0;
        end else begin
            boundary = en && (m_pos + 1 == m_div);
            if (en) m_pos = (m_pos + 1) % m_div;
            m_tick = md ? (m_tick ^ boundary) : boundary;
        end
        if (ld) begin
            m_shadow = nv;
            if (!en || boundary) begin
                m_div     = nv;
                m_pending = 0;
                if (!en) m_pos = 0;
            end else begin
                m_pending = 1;
            end
        end else if (boundary && m_pending) begin
            m_div     = m_shadow;
            m_pending = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit md, input int dv, input bit ld);
        reset     = r;
        enable    = en;
        mode      = md;
        div_value = W'(dv);
        div_load  = ld;
        @(posedge clk_100Mhz);
        model_edge(r, en, md, dv, ld);
        #1;
        chk("tick_out", 32'(tick_out), 32'(m_tick));
        chk("div_active", 32'(div_active), 32'(m_div));
        chk("load_pending", 32'(load_pending), 32'(m_pending));
    endtask

    initial begin
        bit cur_mode;
        bit en;
        bit ld;
        bit rs;
        int dv;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_tick", 32'(tick_out), 32'd0);
        chk("reset_div", 32'(div_active), 32'd10);
        chk("reset_pending", 32'(load_pending), 32'd0);

        // Pulse mode, divide by ten: tick in the cycle after edges 10, 20.
        for (int i = 1; i <= 25; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("pulse_div10", 32'(tick_out), 32'(i % 10 == 0));
        end

        // Square mode: the switch edge clears tick, then 10 high / 10 low.
        cycle(0, 1, 1, 0, 0);
        chk("mode_switch_tick", 32'(tick_out), 32'd0);
        for (int i = 1; i <= 44; i++) begin
            cycle(0, 1, 1, 0, 0);
            chk("square_div10", 32'(tick_out), 32'(((i / 10) % 2) == 1));
        end
        cycle(0, 1, 0, 0, 0);
        chk("mode_back_tick", 32'(tick_out), 32'd0);
        for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0, 0);

        // Load 4 at count 3: old period still finishes at 10.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 4, 1);
        chk("pending_set", 32'(load_pending), 32'd1);
        for (int i = 5; i <= 20; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("load4_ticks", 32'(tick_out), 32'((i == 10) || (i > 10 && (i - 10) % 4 == 0)));
        end

        // Divisor 0 while idle clamps to 1 and applies immediately.
        cycle(0, 0, 0, 0, 1);
        chk("clamp_div", 32'(div_active), 32'd1);
        chk("clamp_pending", 32'(load_pending), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("div1_pulse_high", 32'(tick_out), 32'd1);
        end
        cycle(0, 1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 1, 1, 0, 0);
            chk("div1_square_toggle", 32'(tick_out), 32'(i % 2));
        end

        // Two loads before a boundary: only the last takes effect.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 7, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 3, 1);
        for (int i = 0; i < 15; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("never_seven", 32'(div_active == 16'd7), 32'd0);
        end
        chk("last_load_wins", 32'(div_active), 32'd3);

        // Reset with a pending load, then reset coinciding with a load.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 4, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("rst_pend_div", 32'(div_active), 32'd10);
        chk("rst_pend_pending", 32'(load_pending), 32'd0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 9, 1);
        chk("rst_load_div", 32'(div_active), 32'd10);
        chk("rst_load_pending", 32'(load_pending), 32'd0);

        // Randomized traffic against the reference model.
        cur_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 19) == 0);
            dv = int'($urandom_range(0, 20));
            if (!ld && $urandom_range(0, 59) == 0) cur_mode = ~cur_mode;
            if (rs) cur_mode = 0;
            cycle(rs, en, cur_mode, dv, ld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
